// File: rtl/cc_speedlevels.sv
// cc_speedlevels: classifies valid speed samples into bands 0..NLIMITS against
// programmable thresholds and commits a band change only after DEBOUNCE
// consecutive agreeing valid samples. Keeps the legacy active-low over-limit flag.
module cc_speedlevels #(
    parameter int unsigned DATAWIDTH = 28,
    parameter int unsigned NLIMITS   = 4,
    parameter int unsigned IDXW      = 2,
    parameter int unsigned LEVELW    = 3,
    parameter int unsigned DEBOUNCE  = 3
) (
    input  logic                 CC_SPEEDLEVELS_CLOCK_50,
    input  logic                 CC_SPEEDLEVELS_RESET_InHigh,
    input  logic [DATAWIDTH-1:0] CC_SPEEDLEVELS_data_InBUS,
    input  logic                 CC_SPEEDLEVELS_dataValid_InHigh,
    input  logic [DATAWIDTH-1:0] CC_SPEEDLEVELS_limit_InBUS,
    input  logic [IDXW-1:0]      CC_SPEEDLEVELS_limitIndex_InBUS,
    input  logic                 CC_SPEEDLEVELS_load_InLow,
    output logic [LEVELW-1:0]    CC_SPEEDLEVELS_level_OutBUS,
    output logic                 CC_SPEEDLEVELS_levelChange_OutHigh,
    output logic                 CC_SPEEDLEVELS_signal_OutLow
);

    localparam int unsigned CNTW = 4;

    typedef enum logic {
        ST_STABLE  = 1'b0,
        ST_PENDING = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [LEVELW-1:0]   cand_q, cand_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [CNTW-1:0]     cnt_nxt;
    logic [LEVELW-1:0]   level_q, level_d;
    logic                chg_q, chg_d;
    logic                sig_q, sig_d;
    logic [DATAWIDTH-1:0] limit_q [NLIMITS];
    logic [DATAWIDTH-1:0] limit_d [NLIMITS];
    logic [LEVELW-1:0]   raw_c;

    // Raw band: number of registered thresholds the sample meets or exceeds
    always_comb begin
        raw_c = '0;
        for (int unsigned i = 0; i < NLIMITS; i++) begin
            if (CC_SPEEDLEVELS_data_InBUS >= limit_q[i]) begin
                raw_c = raw_c + LEVELW'(1);
            end
        end
    end

    // Threshold write port; out-of-range slots are silently dropped
    always_comb begin
        limit_d = limit_q;
        if (!CC_SPEEDLEVELS_load_InLow &&
            (32'(CC_SPEEDLEVELS_limitIndex_InBUS) < NLIMITS)) begin
            limit_d[CC_SPEEDLEVELS_limitIndex_InBUS] = CC_SPEEDLEVELS_limit_InBUS;
        end
    end

    // Debounce FSM: track a candidate band and commit after DEBOUNCE agreeing samples
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        cnt_nxt = cnt_q;
        level_d = level_q;
        chg_d   = 1'b0;
        sig_d   = sig_q;
        if (CC_SPEEDLEVELS_dataValid_InHigh) begin
            if (raw_c == level_q) begin
                state_d = ST_STABLE;
                cnt_d   = '0;
            end else begin
                // Same candidate extends the run; anything else restarts it
                if ((state_q == ST_PENDING) && (raw_c == cand_q)) begin
                    cnt_nxt = cnt_q + CNTW'(1);
                end else begin
                    cnt_nxt = CNTW'(1);
                end
                cand_d = raw_c;
                if (cnt_nxt == CNTW'(DEBOUNCE)) begin
                    level_d = raw_c;
                    chg_d   = 1'b1;
                    sig_d   = (raw_c != LEVELW'(NLIMITS));
                    state_d = ST_STABLE;
                    cnt_d   = '0;
                end else begin
                    state_d = ST_PENDING;
                    cnt_d   = cnt_nxt;
                end
            end
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge CC_SPEEDLEVELS_CLOCK_50) begin
        if (CC_SPEEDLEVELS_RESET_InHigh) begin
            state_q <= ST_STABLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            chg_q   <= 1'b0;
            sig_q   <= 1'b1;
            for (int unsigned i = 0; i < NLIMITS; i++) begin
                limit_q[i] <= '1;
            end
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            chg_q   <= chg_d;
            sig_q   <= sig_d;
            limit_q <= limit_d;
        end
    end

    assign CC_SPEEDLEVELS_level_OutBUS        = level_q;
    assign CC_SPEEDLEVELS_levelChange_OutHigh = chg_q;
    assign CC_SPEEDLEVELS_signal_OutLow       = sig_q;

endmodule

// File: tb/tb_cc_speedlevels.sv
// Scoreboard bench for cc_speedlevels: a reference model built on the band
// definition and a sliding window of recent valid bands queues the expected
// outputs per cycle; a monitor on the falling edge pops and compares.
module tb_cc_speedlevels;

    localparam int DW  = 28;
    localparam int NL  = 4;
    localparam int IW  = 2;
    localparam int LW  = 3;
    localparam int DEB = 3;

    logic          clk;
    logic          rst;
    logic [DW-1:0] d_data;
    logic          d_valid;
    logic [DW-1:0] d_lim;
    logic [IW-1:0] d_idx;
    logic          d_load_n;
    logic [LW-1:0] level;
    logic          chg;
    logic          sig;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] m_lim [NL];
    int            m_level;
    logic          m_chg;
    logic          m_sig;
    int            hist[$];
    logic [4:0]    exp_q[$];

    cc_speedlevels #(
        .DATAWIDTH(DW), .NLIMITS(NL), .IDXW(IW), .LEVELW(LW), .DEBOUNCE(DEB)
    ) dut (
        .CC_SPEEDLEVELS_CLOCK_50            (clk),
        .CC_SPEEDLEVELS_RESET_InHigh        (rst),
        .CC_SPEEDLEVELS_data_InBUS          (d_data),
        .CC_SPEEDLEVELS_dataValid_InHigh    (d_valid),
        .CC_SPEEDLEVELS_limit_InBUS         (d_lim),
        .CC_SPEEDLEVELS_limitIndex_InBUS    (d_idx),
        .CC_SPEEDLEVELS_load_InLow          (d_load_n),
        .CC_SPEEDLEVELS_level_OutBUS        (level),
        .CC_SPEEDLEVELS_levelChange_OutHigh (chg),
        .CC_SPEEDLEVELS_signal_OutLow       (sig)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: every cycle the DUT presents registered outputs; compare with queued expectation
    always @(negedge clk) begin
        logic [4:0] e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sb_level", int'(level), int'(e[4:2]));
            chk("sb_change", int'(chg), int'(e[1]));
            chk("sb_signal", int'(sig), int'(e[0]));
        end
    end

    // True when the last DEB valid bands since the last commit all equal b and b differs from the level
    function automatic bit run_done(input int b);
        if (hist.size() < DEB) return 1'b0;
        if (b == m_level) return 1'b0;
        foreach (hist[i]) if (hist[i] != b) return 1'b0;
        return 1'b1;
    endfunction

    // Advance the model with the currently driven inputs, queue the expectation, then clock the DUT
    task automatic tick();
        int n;
        if (rst) begin
            m_level = 0;
            m_chg   = 1'b0;
            m_sig   = 1'b1;
            for (int i = 0; i < NL; i++) m_lim[i] = '1;
            hist.delete();
        end else begin
            m_chg = 1'b0;
            if (d_valid) begin
                n = 0;
                for (int i = 0; i < NL; i++) if (d_data >= m_lim[i]) n++;
                hist.push_back(n);
                while (hist.size() > DEB) void'(hist.pop_front());
                if (run_done(n)) begin
                    m_level = n;
                    m_chg   = 1'b1;
                    m_sig   = (n != NL);
                    hist.delete();
                end
            end
            if (!d_load_n && int'(d_idx) < NL) m_lim[d_idx] = d_lim;
        end
        exp_q.push_back({3'(m_level), m_chg, m_sig});
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic v, input int data,
                         input logic ld_n, input int idx, input int lim);
        rst      = r;
        d_valid  = v;
        d_data   = DW'(data);
        d_load_n = ld_n;
        d_idx    = IW'(idx);
        d_lim    = DW'(lim);
        tick();
    endtask

    task automatic sample(input int data);
        drive(1'b0, 1'b1, data, 1'b1, 0, 0);
    endtask

    task automatic gap();
        drive(1'b0, 1'b0, 0, 1'b1, 0, 0);
    endtask

    task automatic load_std();
        for (int i = 0; i < NL; i++) drive(1'b0, 1'b0, 0, 1'b0, i, 100 * (i + 1));
    endtask

    task automatic reset_and_load();
        drive(1'b1, 1'b0, 0, 1'b1, 0, 0);
        load_std();
    endtask

    initial begin
        int cur;
        // 1: reset and load
        drive(1'b1, 1'b0, 0, 1'b1, 0, 0);
        drive(1'b1, 1'b0, 0, 1'b1, 0, 0);
        chk("rst_level", int'(level), 0);
        chk("rst_change", int'(chg), 0);
        chk("rst_signal", int'(sig), 1);
        load_std();
        for (int i = 0; i < 5; i++) begin
            sample(50);
            chk("low_nochange", int'(chg), 0);
        end
        chk("low_level", int'(level), 0);

        // 2: debounced rise
        sample(250); sample(250);
        chk("rise_early", int'(level), 0);
        sample(250);
        chk("rise_level", int'(level), 2);
        chk("rise_pulse", int'(chg), 1);
        chk("rise_signal", int'(sig), 1);
        gap();
        chk("rise_pulse_end", int'(chg), 0);

        // 3: glitch rejection and valid gaps
        reset_and_load();
        sample(250); sample(250); sample(50); sample(250); sample(250);
        chk("glitch_hold", int'(level), 0);
        sample(250);
        chk("glitch_commit", int'(level), 2);
        sample(320); gap(); sample(320); gap();
        chk("gap_hold", int'(level), 2);
        sample(320);
        chk("gap_commit", int'(level), 3);
        reset_and_load();
        sample(250); sample(250); sample(350); sample(350);
        chk("restart_hold", int'(level), 0);
        sample(350);
        chk("restart_commit", int'(level), 3);

        // 4: boundaries
        sample(400); sample(400); sample(400);
        chk("b400_level", int'(level), 4);
        chk("b400_signal", int'(sig), 0);
        sample(399); sample(399); sample(399);
        chk("b399_level", int'(level), 3);
        chk("b399_signal", int'(sig), 1);

        // 5: load during operation
        reset_and_load();
        sample(250); sample(250); sample(250);
        chk("ld_pre", int'(level), 2);
        drive(1'b0, 1'b1, 250, 1'b0, 1, 300);
        sample(250); sample(250);
        chk("ld_hold", int'(level), 2);
        sample(250);
        chk("ld_commit", int'(level), 1);

        // 6: reset mid-pending
        reset_and_load();
        sample(250); sample(250);
        drive(1'b1, 1'b0, 0, 1'b1, 0, 0);
        sample(250); sample(250);
        chk("rstp_level", int'(level), 0);
        chk("rstp_change", int'(chg), 0);
        sample(250);
        chk("rstp_level3", int'(level), 0);

        // Randomized phase with sticky data to form runs
        reset_and_load();
        cur = 250;
        for (int c = 0; c < 1500; c++) begin
            logic r, v, ln;
            int   sel;
            if ($urandom_range(0, 3) == 0) begin
                sel = $urandom_range(0, 2);
                if (sel == 0)      cur = $urandom_range(0, 520);
                else if (sel == 1) cur = 100 * $urandom_range(1, 4);
                else               cur = 100 * $urandom_range(1, 4) - 1;
            end
            r  = ($urandom_range(0, 199) == 0);
            v  = ($urandom_range(0, 3) != 0);
            ln = ($urandom_range(0, 24) != 0);
            drive(r, v, cur, ln, $urandom_range(0, 3), $urandom_range(0, 500));
        end

        gap();
        @(negedge clk);
        #1;
        chk("sb_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
